// File: rtl/axi_slave_aw_w_arbiter.sv
// Write-path scheduler sitting in front of one slave port.
// Arbitrates the masters' AW requests (QoS first, round-robin tie-break) and
// holds the grant until the granted burst's last W beat has been forwarded,
// so W data from different masters never interleaves at the slave.
//
// Handshake semantics: a transfer happens on a rising ACLK edge where both
// valid and ready are high. Valid never waits on ready. Every ready/valid
// output is a combinational function of the registered state, so all of them
// read 0 while ARESET is high.
module axi_slave_aw_w_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int LEN_WIDTH   = 4,
    parameter int QOS_WIDTH   = 4,
    parameter int QOS_EN      = 1
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_MASTERS-1:0]           req_awvalid,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0] req_awlen,
    input  logic [NUM_MASTERS*QOS_WIDTH-1:0] req_awqos,
    input  logic [NUM_MASTERS-1:0]           req_wvalid,
    input  logic [NUM_MASTERS-1:0]           req_wlast,
    input  logic                             slv_awready,
    input  logic                             slv_wready,
    output logic [NUM_MASTERS-1:0]           req_awready,
    output logic [NUM_MASTERS-1:0]           req_wready,
    output logic                             slv_awvalid,
    output logic                             slv_wvalid,
    output logic                             slv_wlast,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_idx,
    output logic                             busy,
    output logic                             wlast_err,
    output logic [1:0]                       state_dbg
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [IDX_W-1:0]     rr_ptr;

    logic [LEN_WIDTH-1:0] len_arr [NUM_MASTERS];
    logic [QOS_WIDTH-1:0] qos_arr [NUM_MASTERS];

    logic [IDX_W-1:0]     win_idx;
    logic [QOS_WIDTH-1:0] win_qos;
    logic                 win_found;
    logic [QOS_WIDTH-1:0] cur_qos;
    logic [IDX_W:0]       cand;

    logic aw_hs;
    logic w_hs;

    // Unpack the flat per-master AWLEN/AWQOS buses into arrays.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign len_arr[i] = req_awlen[i*LEN_WIDTH +: LEN_WIDTH];
        assign qos_arr[i] = req_awqos[i*QOS_WIDTH +: QOS_WIDTH];
    end

    // Winner search: walk from rr_ptr+1 with wrap; a strictly higher QoS
    // replaces the current pick, so equal QoS keeps the first one found.
    always_comb begin
        win_idx   = '0;
        win_qos   = '0;
        win_found = 1'b0;
        cur_qos   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            end
            if (req_awvalid[cand[IDX_W-1:0]]) begin
                cur_qos = (QOS_EN != 0) ? qos_arr[cand[IDX_W-1:0]] : '0;
                if (!win_found || (cur_qos > win_qos)) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                    win_qos   = cur_qos;
                end
            end
        end
    end

    // Ready/valid gating toward the owner and the slave.
    always_comb begin
        slv_awvalid = (state == ADDR) && req_awvalid[grant_idx];
        req_awready = ((state == ADDR) && slv_awready) ? grant : '0;
        slv_wvalid  = (state == DATA) && req_wvalid[grant_idx];
        req_wready  = ((state == DATA) && slv_wready) ? grant : '0;
        slv_wlast   = (state == DATA) && (beat_cnt == len_q);
    end

    assign aw_hs     = slv_awvalid & slv_awready;
    assign w_hs      = slv_wvalid & slv_wready;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Grant FSM: arbitrate in IDLE, pass the AW in ADDR, count W beats in DATA.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_awvalid) begin
                        grant     <= ONE_HOT_0 << win_idx;
                        grant_idx <= win_idx;
                        len_q     <= len_arr[win_idx];
                        beat_cnt  <= '0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        wlast_err <= (req_wlast[grant_idx] != slv_wlast);
                        if (slv_wlast) begin
                            rr_ptr    <= grant_idx;
                            grant     <= '0;
                            grant_idx <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_slave_aw_w_arbiter.md
Name: axi_slave_aw_w_arbiter

Overview:
Per-slave write-path scheduler for the 4-master/7-slave AXI NoC; one instance sits in front of each slave port. Arbitrates the masters' AW requests and locks the grant until the granted burst's W beats have all been forwarded, so W data never interleaves between masters. Produces grant/select controls and ready/valid gating only; AW/W payload muxing is external, driven by grant_idx.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
LEN_WIDTH, 4, AWLEN width (bursts of 1-16 beats)
QOS_WIDTH, 4, AWQOS width
QOS_EN, 1, 1 = highest QoS wins with round-robin tie-break; 0 = pure round-robin

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
req_awvalid  in  NUM_MASTERS  per-master AWVALID
req_awlen  in  NUM_MASTERS*LEN_WIDTH  per-master AWLEN, master i at [i*LEN_WIDTH +: LEN_WIDTH]
req_awqos  in  NUM_MASTERS*QOS_WIDTH  per-master AWQOS, same packing
req_wvalid  in  NUM_MASTERS  per-master WVALID
req_wlast  in  NUM_MASTERS  per-master WLAST
slv_awready  in  1  slave AWREADY
slv_wready  in  1  slave WREADY
req_awready  out  NUM_MASTERS  AWREADY returned to masters
req_wready  out  NUM_MASTERS  WREADY returned to masters
slv_awvalid  out  1  AWVALID to slave
slv_wvalid  out  1  WVALID to slave
slv_wlast  out  1  WLAST to slave, generated from the beat counter
grant  out  NUM_MASTERS  one-hot current owner
grant_idx  out  $clog2(NUM_MASTERS)  binary index of owner, mux select
busy  out  1  high whenever state != IDLE
wlast_err  out  1  one-cycle pulse on a WLAST/length mismatch

Behaviour:
- Reset (ARESET=1, asynchronous):
  - state=IDLE; grant=0, grant_idx=0, beat_cnt=0, busy=0, wlast_err=0.
  - rr_ptr=NUM_MASTERS-1, so master 0 wins the first tie.
  - All *ready/*valid outputs are 0 (combinational from state, so 0 while in reset).
  - Reset mid-burst abandons the burst immediately; no recovery beats are generated.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If any req_awvalid is set, register the winner into grant/grant_idx, latch its AWLEN into len_q, clear beat_cnt, and go to ADDR.
  - Arbitration latency: 1 cycle from AWVALID to slv_awvalid.
  - Winner with QOS_EN=1: among requesters, the maximum AWQOS; ties go to the first requester found searching from rr_ptr+1 upward with wrap.
  - Winner with QOS_EN=0: first requester from rr_ptr+1 with wrap.
- ADDR:
  - slv_awvalid = req_awvalid[g]; req_awready[g] = slv_awready; all other req_awready are 0.
  - Go to DATA on slv_awvalid & slv_awready.
  - Grant is held even if the owner drops AWVALID; that is a protocol violation and is not handled.
  - New requests from other masters are ignored.
- DATA:
  - slv_wvalid = req_wvalid[g]; req_wready[g] = slv_wready; slv_wlast = (beat_cnt == len_q).
  - Each W handshake increments beat_cnt.
  - On a handshake where req_wlast[g] != slv_wlast, wlast_err pulses in the next cycle.
  - The slave always receives the correct count: len_q+1 beats.
  - On the final-beat handshake: rr_ptr=grant_idx, grant cleared, next state IDLE.
  - One idle bubble between bursts is required.
- W beats arriving before AW is accepted stall: req_wready=0 outside DATA.
- A non-granted master never sees any ready asserted.
- beat_cnt width is LEN_WIDTH; len_q=15 gives 16 beats with no overflow.

Test Plan:
1. Reset, then M1 requests alone with AWLEN=3, QoS=0, slave always ready → slv_awvalid rises 1 cycle later; grant=0010; exactly 4 W beats forwarded with slv_wlast on beat 4; busy falls the cycle after.
2. M0–M3 request simultaneously, equal QoS, AWLEN=0 each, kept re-asserting → grant order M0, M1, M2, M3, M0.
3. QOS_EN=1: M0 has QoS=2, M3 has QoS=9, both requesting → M3 granted first, then M0.
4. M2 granted with AWLEN=7; slv_wready toggles 1/0 each cycle; M0 requests mid-burst → 8 beats forwarded in 16 cycles; M0 receives no AWREADY until M2's beat 8 completes.
5. M1 granted with AWLEN=2 but asserts WLAST on beat 2 → wlast_err pulses once; slave still receives 3 beats with slv_wlast on beat 3.
6. ARESET asserted during DATA at beat 3 of 8 → all outputs 0 in the same cycle; after release, state is IDLE and a new M3 request is granted cleanly.
